// File: rtl/intr_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | intr_sequencer_pkg                                                 |
// | Exception codes, SPR numbers, MSR bit map and FSM state encodings. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package intr_sequencer_pkg;

    localparam int c_EXC_CODE_W = 4;
    typedef logic [c_EXC_CODE_W-1:0] exc_code_t;

    localparam exc_code_t c_EXC_NONE     = 4'h0;
    localparam exc_code_t c_EXC_CRITICAL = 4'h1;
    localparam exc_code_t c_EXC_MCHECK   = 4'h2;
    localparam exc_code_t c_EXC_DSI      = 4'h3;
    localparam exc_code_t c_EXC_ISI      = 4'h4;
    localparam exc_code_t c_EXC_EXTERNAL = 4'h5;
    localparam exc_code_t c_EXC_ALIGN    = 4'h6;
    localparam exc_code_t c_EXC_PROGRAM  = 4'h7;
    localparam exc_code_t c_EXC_SC       = 4'h9;
    localparam exc_code_t c_EXC_TRAP     = 4'hA;
    localparam exc_code_t c_EXC_DMISS    = 4'hB;
    localparam exc_code_t c_EXC_IMISS    = 4'hC;

    typedef logic [9:0] sprn_t;
    localparam sprn_t c_SPRN_SRR0 = 10'd26;
    localparam sprn_t c_SPRN_SRR1 = 10'd27;
    localparam sprn_t c_SPRN_DEAR = 10'd61;

    // MSR positions use big-endian numbering: bit 0 is the MSB.
    localparam int c_MSR_EE_POS = 16;
    localparam int c_MSR_PR_POS = 17;
    localparam int c_MSR_IS_POS = 26;
    localparam int c_MSR_DS_POS = 27;

    function automatic logic [31:0] msr_bit(input int pos);
        return 32'h8000_0000 >> pos;
    endfunction

    localparam logic [31:0] c_MSR_CLR_MASK = msr_bit(c_MSR_EE_POS) | msr_bit(c_MSR_PR_POS)
                                           | msr_bit(c_MSR_IS_POS) | msr_bit(c_MSR_DS_POS);

    typedef logic [3:0] state_t;
    localparam state_t c_ST_IDLE      = 4'd0;
    localparam state_t c_ST_DRAIN     = 4'd1;
    localparam state_t c_ST_SAVE_SRR0 = 4'd2;
    localparam state_t c_ST_SAVE_SRR1 = 4'd3;
    localparam state_t c_ST_SAVE_DEAR = 4'd4;
    localparam state_t c_ST_REDIRECT  = 4'd5;
    localparam state_t c_ST_ACK       = 4'd6;
    localparam state_t c_ST_RFI_SRR0  = 4'd7;
    localparam state_t c_ST_RFI_SRR1  = 4'd8;
    localparam state_t c_ST_RFI_DONE  = 4'd9;

    // Data-side faults also record the faulting address in DEAR.
    function automatic logic is_data_fault(input exc_code_t code);
        return (code == c_EXC_DSI) || (code == c_EXC_DMISS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/intr_sequencer_if.sv
// +--------------------------------------------------------------------+
// | intr_sequencer_if                                                  |
// | Encoder, register-file SPR port and pipeline control bundle.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface intr_sequencer_if #(
    parameter int EXC_W = 4
);
    logic [EXC_W-1:0] excep_code;
    logic [31:0]      entry_addr;
    logic [31:0]      epc;
    logic [31:0]      fault_addr;
    logic [31:0]      msr_in;
    logic             rfi_req;
    logic             pipe_empty;
    logic [31:0]      spr_rd;
    logic [9:0]       spr_addr;
    logic [31:0]      spr_wd;
    logic             spr_wr;
    logic             ack;
    logic             pipe_flush;
    logic             pipe_stall;
    logic             pc_load;
    logic [31:0]      pc_next;
    logic             msr_we;
    logic [31:0]      msr_wd;
    logic             busy;
    logic             rfi_done;
    logic             drain_err;

    modport master (
        input  excep_code, entry_addr, epc, fault_addr, msr_in, rfi_req, pipe_empty, spr_rd,
        output spr_addr, spr_wd, spr_wr, ack, pipe_flush, pipe_stall, pc_load, pc_next,
               msr_we, msr_wd, busy, rfi_done, drain_err
    );

    modport slave (
        output excep_code, entry_addr, epc, fault_addr, msr_in, rfi_req, pipe_empty, spr_rd,
        input  spr_addr, spr_wd, spr_wr, ack, pipe_flush, pipe_stall, pc_load, pc_next,
               msr_we, msr_wd, busy, rfi_done, drain_err
    );
endinterface

`default_nettype wire

// File: rtl/intr_drain_timer.sv
// +--------------------------------------------------------------------+
// | intr_drain_timer                                                   |
// | Bounded wait for pipeline drain with sticky timeout flag.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module intr_drain_timer #(
    parameter int DRAIN_MAX = 16
) (
    input  wire  clk,
    input  wire  rst,
    input  logic en,
    input  logic pipe_empty,
    output logic done,
    output logic drain_err
);
    localparam int c_CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DRAIN_MAX - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_last;
    logic               w_timeout;

    assign w_last    = (r_cnt == c_CNT_LAST);
    assign done      = en && (pipe_empty || w_last);
    // A drained pipe on the final count is a normal exit, not a timeout.
    assign w_timeout = en && !pipe_empty && w_last;
    assign drain_err = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (en && !done) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/intr_sequencer.sv
// +--------------------------------------------------------------------+
// | intr_sequencer                                                     |
// | Interrupt entry (drain/save/redirect/ack) and rfi return sequencer.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module intr_sequencer
    import intr_sequencer_pkg::*;
#(
    parameter int          EXC_W        = 4,
    parameter int          DRAIN_MAX    = 16,
    parameter logic [31:0] MSR_CLR_MASK = c_MSR_CLR_MASK
) (
    input wire clk,
    input wire rst,
    intr_sequencer_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    logic [EXC_W-1:0] r_code;
    logic [31:0]      r_epc;
    logic [31:0]      r_msr;
    logic [31:0]      r_fault;
    logic [31:0]      r_entry;
    logic [31:0]      r_pc_tmp;
    logic [31:0]      r_msr_tmp;
    logic             r_guard;
    logic             w_accept;
    logic             w_data_fault;
    logic             w_in_drain;
    logic             w_drain_done;
    logic             w_drain_err;

    logic [9:0]       w_spr_addr;
    logic [31:0]      w_spr_wd;
    logic             w_spr_wr;
    logic             w_ack;
    logic             w_flush;
    logic             w_busy;
    logic             w_pc_load;
    logic [31:0]      w_pc_next;
    logic             w_msr_we;
    logic [31:0]      w_msr_wd;
    logic             w_rfi_done;

    assign w_accept     = (r_state == c_ST_IDLE) && (bus.excep_code != EXC_W'(c_EXC_NONE)) && !r_guard;
    assign w_data_fault = is_data_fault(c_EXC_CODE_W'(r_code));
    assign w_in_drain   = (r_state == c_ST_DRAIN);
    assign w_busy       = (r_state != c_ST_IDLE);

    intr_drain_timer #(
        .DRAIN_MAX (DRAIN_MAX)
    ) u_drain_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (w_in_drain),
        .pipe_empty (bus.pipe_empty),
        .done       (w_drain_done),
        .drain_err  (w_drain_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // Exception beats a same-cycle rfi; the rfi pulse is lost.
                if (w_accept) begin
                    w_next = c_ST_DRAIN;
                end else if (bus.rfi_req) begin
                    w_next = c_ST_RFI_SRR0;
                end
            end
            c_ST_DRAIN:     w_next = w_drain_done ? c_ST_SAVE_SRR0 : c_ST_DRAIN;
            c_ST_SAVE_SRR0: w_next = c_ST_SAVE_SRR1;
            c_ST_SAVE_SRR1: w_next = w_data_fault ? c_ST_SAVE_DEAR : c_ST_REDIRECT;
            c_ST_SAVE_DEAR: w_next = c_ST_REDIRECT;
            c_ST_REDIRECT:  w_next = c_ST_ACK;
            c_ST_ACK:       w_next = c_ST_IDLE;
            c_ST_RFI_SRR0:  w_next = c_ST_RFI_SRR1;
            c_ST_RFI_SRR1:  w_next = c_ST_RFI_DONE;
            c_ST_RFI_DONE:  w_next = c_ST_IDLE;
            default:        w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_spr_addr = '0;
        w_spr_wd   = '0;
        w_spr_wr   = 1'b0;
        w_ack      = 1'b0;
        w_flush    = 1'b0;
        w_pc_load  = 1'b0;
        w_pc_next  = '0;
        w_msr_we   = 1'b0;
        w_msr_wd   = '0;
        w_rfi_done = 1'b0;
        case (r_state)
            c_ST_DRAIN: w_flush = 1'b1;
            c_ST_SAVE_SRR0: begin
                w_spr_wr   = 1'b1;
                w_spr_addr = c_SPRN_SRR0;
                w_spr_wd   = r_epc;
            end
            c_ST_SAVE_SRR1: begin
                w_spr_wr   = 1'b1;
                w_spr_addr = c_SPRN_SRR1;
                w_spr_wd   = r_msr;
            end
            c_ST_SAVE_DEAR: begin
                w_spr_wr   = 1'b1;
                w_spr_addr = c_SPRN_DEAR;
                w_spr_wd   = r_fault;
            end
            c_ST_REDIRECT: begin
                w_pc_load = 1'b1;
                w_pc_next = r_entry;
                w_msr_we  = 1'b1;
                w_msr_wd  = r_msr & ~MSR_CLR_MASK;
            end
            c_ST_ACK:      w_ack = 1'b1;
            c_ST_RFI_SRR0: w_spr_addr = c_SPRN_SRR0;
            c_ST_RFI_SRR1: w_spr_addr = c_SPRN_SRR1;
            c_ST_RFI_DONE: begin
                w_pc_load  = 1'b1;
                w_pc_next  = r_pc_tmp;
                w_msr_we   = 1'b1;
                w_msr_wd   = r_msr_tmp;
                w_rfi_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= '0;
            r_epc   <= '0;
            r_msr   <= '0;
            r_fault <= '0;
            r_entry <= '0;
        end else if (w_accept) begin
            r_code  <= bus.excep_code;
            r_epc   <= bus.epc;
            r_msr   <= bus.msr_in;
            r_fault <= bus.fault_addr;
            r_entry <= bus.entry_addr;
        end
    end

    // Encoder still shows the old code in the first IDLE cycle after ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_guard <= 1'b0;
        end else begin
            r_guard <= (r_state == c_ST_ACK);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_tmp  <= '0;
            r_msr_tmp <= '0;
        end else begin
            if (r_state == c_ST_RFI_SRR0) begin
                r_pc_tmp <= bus.spr_rd;
            end
            if (r_state == c_ST_RFI_SRR1) begin
                r_msr_tmp <= bus.spr_rd;
            end
        end
    end

    assign bus.spr_addr   = w_spr_addr;
    assign bus.spr_wd     = w_spr_wd;
    assign bus.spr_wr     = w_spr_wr;
    assign bus.ack        = w_ack;
    assign bus.pipe_flush = w_flush;
    assign bus.pipe_stall = w_busy;
    assign bus.pc_load    = w_pc_load;
    assign bus.pc_next    = w_pc_next;
    assign bus.msr_we     = w_msr_we;
    assign bus.msr_wd     = w_msr_wd;
    assign bus.busy       = w_busy;
    assign bus.rfi_done   = w_rfi_done;
    assign bus.drain_err  = w_drain_err;

endmodule

`default_nettype wire

// File: tb/tb_intr_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_intr_sequencer                                                  |
// | Randomized self-checking bench with a cycle-level reference model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_intr_sequencer;
    import intr_sequencer_pkg::*;

    localparam logic [31:0] c_MASK = 32'h0000_C030;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        exp_err  = 1'b0;
    logic [31:0] exp_srr0 = '0;
    logic [31:0] exp_srr1 = '0;
    logic [31:0] srf [0:1023];

    intr_sequencer_if #(.EXC_W(4)) bus_if ();

    intr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, write on the clock edge.
    assign bus_if.spr_rd = srf[bus_if.spr_addr];
    always @(posedge clk) begin
        if (bus_if.spr_wr) srf[bus_if.spr_addr] <= bus_if.spr_wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [114:0] out_vec();
        return {bus_if.spr_addr, bus_if.spr_wd, bus_if.spr_wr, bus_if.ack, bus_if.pipe_flush,
                bus_if.pipe_stall, bus_if.pc_load, bus_if.pc_next, bus_if.msr_we, bus_if.msr_wd,
                bus_if.busy, bus_if.rfi_done, bus_if.drain_err};
    endfunction

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", out_vec());
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, want 0", bus_if.busy);
        end
    endtask

    // Runs one interrupt entry; d = number of DRAIN cycles with pipe_empty low.
    task automatic run_entry(input logic [3:0] code, input logic [31:0] epc, input logic [31:0] msr,
                             input logic [31:0] fault, input logic [31:0] entry, input int d,
                             input bit with_rfi, input string tag);
        int f = 0, k, ack_cyc = 0, ack_n = 0, pcl_cyc = 0, pcl_n = 0, rfi_n = 0, wr_n = 0;
        int bad_stall = 0, bad_we = 0, dl, dear, exp_n;
        int          wr_cyc [8];
        logic [9:0]  wr_addr [8];
        logic [31:0] wr_data [8];
        logic [31:0] pcl_pc = '0, pcl_msr = '0;
        int          e_cyc [3];
        logic [9:0]  e_addr [3];
        logic [31:0] e_data [3];

        bus_if.excep_code = code;
        bus_if.epc        = epc;
        bus_if.msr_in     = msr;
        bus_if.fault_addr = fault;
        bus_if.entry_addr = entry;
        bus_if.rfi_req    = with_rfi;
        bus_if.pipe_empty = (d == 0);
        for (k = 1; k <= 60 && ack_n == 0; k++) begin
            tick();
            bus_if.rfi_req = 1'b0;
            if (k == 1) begin
                bus_if.epc        = $urandom;
                bus_if.msr_in     = $urandom;
                bus_if.fault_addr = $urandom;
                bus_if.entry_addr = $urandom;
            end
            if (bus_if.pipe_flush) f++;
            bus_if.pipe_empty = (f > d);
            if (bus_if.spr_wr) begin
                if (wr_n < 8) begin
                    wr_cyc[wr_n]  = k;
                    wr_addr[wr_n] = bus_if.spr_addr;
                    wr_data[wr_n] = bus_if.spr_wd;
                end
                wr_n++;
            end
            if (bus_if.pc_load) begin
                pcl_n++;
                pcl_cyc = k;
                pcl_pc  = bus_if.pc_next;
                pcl_msr = bus_if.msr_wd;
            end
            if (bus_if.msr_we !== bus_if.pc_load) bad_we++;
            if (bus_if.rfi_done) rfi_n++;
            if (bus_if.busy !== 1'b1 || bus_if.pipe_stall !== 1'b1) bad_stall++;
            if (bus_if.ack) begin
                ack_n++;
                ack_cyc = k;
            end
        end
        checks++;
        if (ack_n == 0) begin
            errors++;
            $display("FAIL %s ack_timeout: no ack within 60 cycles, want one", tag);
            bus_if.excep_code = c_EXC_NONE;
            return;
        end

        // Code still held during the first IDLE cycle: must not re-enter.
        tick();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL %s guard: busy=%b ack=%b, want 0 0", tag, bus_if.busy, bus_if.ack);
        end
        bus_if.excep_code = c_EXC_NONE;
        bus_if.pipe_empty = 1'b1;
        tick();
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b, want 0", tag, bus_if.busy);
        end

        dear  = (code == c_EXC_DSI || code == c_EXC_DMISS) ? 1 : 0;
        dl    = (d + 1 < 16) ? d + 1 : 16;
        exp_n = 2 + dear;
        e_addr[0] = 10'd26; e_data[0] = epc;
        e_addr[1] = 10'd27; e_data[1] = msr;
        e_addr[2] = 10'd61; e_data[2] = fault;
        for (int i = 0; i < 3; i++) e_cyc[i] = dl + 1 + i;
        if (d >= 16) exp_err = 1'b1;

        checks++;
        if (ack_cyc != dl + 4 + dear) begin
            errors++;
            $display("FAIL %s ack_latency: got %0d, want %0d", tag, ack_cyc, dl + 4 + dear);
        end
        checks++;
        if (f != dl) begin
            errors++;
            $display("FAIL %s drain_cycles: got %0d, want %0d", tag, f, dl);
        end
        checks++;
        if (wr_n != exp_n) begin
            errors++;
            $display("FAIL %s spr_write_count: got %0d, want %0d", tag, wr_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < wr_n; i++) begin
            checks++;
            if (wr_cyc[i] != e_cyc[i] || wr_addr[i] !== e_addr[i] || wr_data[i] !== e_data[i]) begin
                errors++;
                $display("FAIL %s spr_write%0d: got cyc=%0d addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                         tag, i, wr_cyc[i], wr_addr[i], wr_data[i], e_cyc[i], e_addr[i], e_data[i]);
            end
        end
        checks++;
        if (pcl_n != 1 || pcl_cyc != dl + 3 + dear || pcl_pc !== entry || pcl_msr !== (msr & ~c_MASK)) begin
            errors++;
            $display("FAIL %s redirect: got n=%0d cyc=%0d pc=%h msr=%h, want n=1 cyc=%0d pc=%h msr=%h",
                     tag, pcl_n, pcl_cyc, pcl_pc, pcl_msr, dl + 3 + dear, entry, msr & ~c_MASK);
        end
        checks++;
        if (bad_stall != 0 || bad_we != 0 || rfi_n != 0) begin
            errors++;
            $display("FAIL %s strobes: stall_bad=%0d we_bad=%0d rfi_done=%0d, want 0 0 0",
                     tag, bad_stall, bad_we, rfi_n);
        end
        checks++;
        if (bus_if.drain_err !== exp_err) begin
            errors++;
            $display("FAIL %s drain_err: got %b, want %b", tag, bus_if.drain_err, exp_err);
        end
        exp_srr0 = epc;
        exp_srr1 = msr;
    endtask

    task automatic test_rfi(input string tag);
        int done_cyc = 0, done_n = 0, wr_n = 0, ack_n = 0;
        logic [31:0] pc = '0, m = '0;
        bus_if.rfi_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus_if.rfi_req = 1'b0;
            if (bus_if.spr_wr) wr_n++;
            if (bus_if.ack) ack_n++;
            if (bus_if.rfi_done) begin
                done_n++;
                done_cyc = k;
                pc = bus_if.pc_load ? bus_if.pc_next : 32'hBAD0_BAD0;
                m  = bus_if.msr_we ? bus_if.msr_wd : 32'hBAD0_BAD0;
            end
        end
        checks++;
        if (done_n != 1 || done_cyc != 3) begin
            errors++;
            $display("FAIL %s rfi_timing: got n=%0d cyc=%0d, want n=1 cyc=3", tag, done_n, done_cyc);
        end
        checks++;
        if (pc !== exp_srr0 || m !== exp_srr1) begin
            errors++;
            $display("FAIL %s rfi_restore: got pc=%h msr=%h, want pc=%h msr=%h", tag, pc, m, exp_srr0, exp_srr1);
        end
        checks++;
        if (wr_n != 0 || ack_n != 0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s rfi_side: got wr=%0d ack=%0d busy=%b, want 0 0 0", tag, wr_n, ack_n, bus_if.busy);
        end
    endtask

    task automatic test_directed();
        run_entry(c_EXC_DSI, 32'h0000_1000, 32'h0000_C000, 32'hDEAD_0004, 32'hFFFF_0200, 0, 1'b0, "dsi");
        run_entry(c_EXC_SC, 32'h0000_2000, 32'h0000_8000, 32'h1111_2222, 32'hFFFF_0C00, 0, 1'b0, "sc");
        test_rfi("rfi_directed");
    endtask

    task automatic test_random();
        logic [3:0] codes [8];
        codes = '{c_EXC_DSI, c_EXC_DMISS, c_EXC_SC, c_EXC_TRAP, c_EXC_ISI, c_EXC_EXTERNAL,
                  c_EXC_PROGRAM, c_EXC_ALIGN};
        for (int i = 0; i < 10; i++) begin
            run_entry(codes[$urandom_range(0, 7)], $urandom, $urandom, $urandom, $urandom,
                      $urandom_range(0, 15), 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) test_rfi("rfi_rand");
        end
    endtask

    task automatic test_drain_timeout();
        run_entry(c_EXC_SC, 32'h0000_3000, 32'h0000_4030, 32'h0, 32'hFFFF_0C00, 40, 1'b0, "timeout");
    endtask

    task automatic test_same_cycle();
        run_entry(c_EXC_TRAP, 32'h0000_5000, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_0700, 2, 1'b1, "trap_rfi");
    endtask

    task automatic test_reset_mid_sequence();
        bus_if.excep_code = c_EXC_DSI;
        bus_if.epc        = 32'h0000_6000;
        bus_if.msr_in     = 32'h0000_C010;
        bus_if.fault_addr = 32'hCAFE_0008;
        bus_if.entry_addr = 32'hFFFF_0300;
        bus_if.pipe_empty = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus_if.spr_wr !== 1'b1 || bus_if.spr_addr !== 10'd27) begin
            errors++;
            $display("FAIL reset_mid_pre: got wr=%b addr=%0d, want 1 27", bus_if.spr_wr, bus_if.spr_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h, want 0", out_vec());
        end
        exp_err = 1'b0;
        tick();
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_held: busy=%b, want 0", bus_if.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        run_entry(c_EXC_DSI, 32'h0000_6000, 32'h0000_C010, 32'hCAFE_0008, 32'hFFFF_0300, 0, 1'b0, "restart");
    endtask

    initial begin
        bus_if.excep_code = c_EXC_NONE;
        bus_if.entry_addr = '0;
        bus_if.epc        = '0;
        bus_if.fault_addr = '0;
        bus_if.msr_in     = '0;
        bus_if.rfi_req    = 1'b0;
        bus_if.pipe_empty = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_same_cycle();
        test_drain_timeout();
        test_rfi("rfi_after_timeout");
        test_reset_mid_sequence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
